// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Used by the arbiter top and the round-robin picker.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] TAG_BASE = 8'hF0;
  localparam int CNT_W = 8;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between requesters, arbiter and the
// USB-serial bridge input.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              uart_in_valid;
  logic [7:0]        uart_in_data;
  logic              uart_in_ready;

  modport master (
    input  req_valid,
    input  req_data,
    input  uart_in_ready,
    output req_ready,
    output uart_in_valid,
    output uart_in_data
  );

  modport slave (
    output req_valid,
    output req_data,
    output uart_in_ready,
    input  req_ready,
    input  uart_in_valid,
    input  uart_in_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request after
// the last grant, wrapping modulo N.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = gid_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] nxt,
  output logic         any_valid
);

  int best;

  // Nearest requester by rotated distance from last+1
  always_comb begin
    nxt       = last;
    any_valid = 1'b0;
    best      = N;
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i + N - 1 - int'(last)) % N;
      if (req[i] && d < best) begin
        best      = d;
        nxt       = W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for the UART TX byte
// channel. Optional grant tag byte: UART_TX_ARBITER_TAG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NREQ        = 2,
  parameter int         MAX_BURST   = 64,
  parameter logic [7:0] EOP_BYTE    = 8'h0A,
  parameter int         GAP_TIMEOUT = 8,
  localparam int        GW          = gid_w(NREQ)
) (
  input  logic                CLK,
  input  logic                reset,
  uart_tx_arbiter_if.master   bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_LOCKED = LOCKED;

  localparam logic [CNT_W-1:0] BURST_LAST =
    CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_TIMEOUT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             tag_pending;
  logic             tag_load;
  logic [7:0]       tag_byte;

  logic [GW-1:0]    pick;
  logic             any_req;
  logic             gnt_valid;
  logic [7:0]       gnt_data;
  logic             locked;
  logic             can_load;
  logic             open;
  logic             accept;
  logic             eop_hit;
  logic             burst_hit;
  logic             gap_hit;
  logic             release_now;

  rr_pick #(
    .N (NREQ),
    .W (GW)
  ) u_pick (
    .req       (bus.req_valid),
    .last      (grant_id),
    .nxt       (pick),
    .any_valid (any_req)
  );

  // Select the current grantee's valid and byte
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == grant_id) begin
        gnt_valid = bus.req_valid[i];
        gnt_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign locked   = (state == S_LOCKED);
  assign can_load = !out_valid || bus.uart_in_ready;
  assign open     = locked && can_load && !tag_pending;
  assign accept   = open && gnt_valid;

  assign eop_hit   = accept && (gnt_data == EOP_BYTE);
  assign burst_hit = accept && (burst_cnt == BURST_LAST);
  assign gap_hit   = locked && !gnt_valid &&
                     (gap_cnt == GAP_LAST);
  assign release_now = eop_hit || burst_hit || gap_hit;

  // Only the grantee sees ready, and only when a byte can load
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = open && (GW'(i) == grant_id);
    end
  end

  assign bus.uart_in_valid = out_valid;
  assign bus.uart_in_data  = out_data;
  assign busy              = locked;

`ifdef UART_TX_ARBITER_TAG_EN
  assign tag_load = locked && tag_pending && can_load;
  assign tag_byte = TAG_BASE | 8'(grant_id);

  // Tag owed at the start of every grant until it loads
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tag_pending <= 1'b0;
    end else if (!locked && any_req) begin
      tag_pending <= 1'b1;
    end else if (tag_load || release_now) begin
      tag_pending <= 1'b0;
    end
  end
`else
  assign tag_pending = 1'b0;
  assign tag_load    = 1'b0;
  assign tag_byte    = TAG_BASE;
`endif

  // Single output register; refills in the cycle it drains
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (tag_load) begin
      out_valid <= 1'b1;
      out_data  <= tag_byte;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
    end else if (bus.uart_in_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Grant FSM with burst and idle-gap release counters
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      grant_id  <= GW'(NREQ - 1);
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            state    <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (release_now) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
            gap_cnt   <= '0;
          end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
            gap_cnt   <= '0;
          end else if (!gnt_valid) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NREQ=2, MAX_BURST=4,
// GAP_TIMEOUT=8); follows UART_TX_ARBITER_TAG_EN if defined.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int MB   = 4;
  localparam int GAP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gid;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .MAX_BURST   (MB),
    .EOP_BYTE    (8'h0A),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .CLK      (clk),
    .reset    (rst),
    .bus      (bus),
    .grant_id (gid),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic send(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (r == 0) rq0.push_back(s[i]);
      else        rq1.push_back(s[i]);
    end
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic expect_tag(input int r);
`ifdef UART_TX_ARBITER_TAG_EN
    exp_q.push_back(8'hF0 | 8'(r));
`else
    if (r < 0) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, busy, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 80) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(input string nm);
    int n = 0;
    while (!bus.uart_in_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, bus.uart_in_valid, 1);
  endtask

  // Requester models: present queue heads, pop on handshake
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      bus.req_valid[0]   = rq0.size() > 0;
      bus.req_data[7:0]  = rq0.size() > 0 ? rq0[0] : 8'h00;
      bus.req_valid[1]   = rq1.size() > 0;
      bus.req_data[15:8] = rq1.size() > 0 ? rq1[0] : 8'h00;
      #4;
      if (bus.req_valid[0] && bus.req_ready[0] &&
          rq0.size() > 0)
        void'(rq0.pop_front());
      if (bus.req_valid[1] && bus.req_ready[1] &&
          rq1.size() > 0)
        void'(rq1.pop_front());
    end
  end

  // Monitor: compare every byte the bridge accepts
  initial begin
    forever begin
      @(negedge clk); #4;
      if (!rst && bus.uart_in_valid && bus.uart_in_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h want none",
                   bus.uart_in_data);
        end else begin
          chk("uart_byte", bus.uart_in_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    int bad;
    bus.uart_in_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.uart_in_valid, 0);
    chk("rst_out_data", bus.uart_in_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_grant_id", gid, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // single line from requester 0
    expect_tag(0); expect_str("hi\n");
    send(0, "hi\n");
    wait_busy("t1_busy");
    chk("t1_grant", gid, 0);
    chk("t1_no_ready_other", bus.req_ready[1], 0);
    wait_empty("t1_drain");
    chk("t1_busy_after_eop", busy, 0);

    // both streaming lines; last grant 0 so 1 goes first
    expect_tag(1); expect_str("AB\n");
    expect_tag(0); expect_str("ab\n");
    expect_tag(1); expect_str("CD\n");
    expect_tag(0); expect_str("cd\n");
    send(0, "ab\ncd\n");
    send(1, "AB\nCD\n");
    wait_empty("t2_drain");
    wait_idle("t2_idle");

    // burst limit: 4 from req1, req0 packet, req1 resumes
    expect_tag(1); expect_str("0123");
    expect_tag(0); expect_str("xy\n");
    expect_tag(1); expect_str("4567");
    expect_tag(1); expect_str("89");
    send(1, "0123456789");
    wait_busy("t3_busy");
    chk("t3_grant", gid, 1);
    send(0, "xy\n");
    wait_empty("t3_drain");
    wait_idle("t3_idle");

    // gap release after exactly GAP idle cycles
    expect_tag(0); expect_str("g");
    expect_tag(1); expect_str("z\n");
    send(0, "g");
    send(1, "z\n");
    n = 0;
    while (rq0.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("t4_g_taken", rq0.size(), 0);
    chk("t4_grant", gid, 0);
    n = 0;
    while (busy && gid == 1'b0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("t4_gap_cycles", n, GAP);
    wait_empty("t4_drain");
    wait_idle("t4_idle");

    // output stall must not release and must hold data
    expect_tag(0); expect_str("st\n");
    send(0, "st\n");
    wait_out_valid("t5_valid");
    bus.uart_in_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 || !bus.uart_in_valid ||
          !busy || bus.uart_in_data !== exp_q[0])
        bad++;
    end
    chk("t5_stall_stable", bad, 0);
    chk("t5_stall_busy", busy, 1);
    bus.uart_in_ready = 1'b1;
    wait_empty("t5_drain");
    wait_idle("t5_idle");

    // reset mid-packet with a byte held in the output
    expect_tag(0); expect_str("rr\n");
    send(0, "rr\n");
    wait_out_valid("t6_valid");
    bus.uart_in_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", bus.uart_in_valid, 0);
    chk("t6_rst_req_ready", bus.req_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", gid, 1);
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.uart_in_ready = 1'b1;
    expect_tag(0); expect_str("P\n");
    expect_tag(1); expect_str("Q\n");
    send(1, "Q\n");
    send(0, "P\n");
    wait_busy("t6_busy");
    chk("t6_first_grant", gid, 0);
    wait_empty("t6_drain");
    wait_idle("t6_idle");

    // tag or plain data from requester 1
    expect_tag(1); expect_str("A\n");
    send(1, "A\n");
    wait_empty("t7_drain");
    wait_idle("t7_idle");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
